vga_scanout: RTL and testbench

VGA_SCANOUT -- requirements
Module: vga_scanout

---
 rtl/vga_scanout.sv | 165 ++++++++++++++++
 tb/tb_vga_scanout.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator with frame-buffer fetch and palette lookup
// Counters drive the fetch address; control bits ride a delay line that matches read latency.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IDX_W    = 3,
  parameter int RD_LAT   = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int AW      = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pal_we,
  input  logic [IDX_W-1:0] pal_addr,
  input  logic [23:0]      pal_data,
  output logic [AW-1:0]    fb_raddr,
  input  logic [IDX_W-1:0] fb_rdata,
  output logic             blank,
  output logic             hsync,
  output logic             vsync,
  output logic             comp_sync,
  output logic [7:0]       pixel_r,
  output logic [7:0]       pixel_g,
  output logic [7:0]       pixel_b,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int PAL_N   = 2 ** IDX_W;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW-1:0] A_LAST   = AW'(H_ACTIVE * V_ACTIVE - 1);
  localparam bit            BOTH_LOW = !HS_POL && !VS_POL;

  function automatic logic [23:0] pal_default(input int idx);
    case (idx)
      1:       return 24'h00FF00;
      2:       return 24'h0000FF;
      3:       return 24'hFF0000;
      4:       return 24'h66FFFF;
      5:       return 24'hD3D3D3;
      6:       return 24'hFFFFFF;
      7:       return 24'hCCFF99;
      default: return 24'h000000;
    endcase
  endfunction

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [AW-1:0] addr;
  logic          active;
  logic          act0, hs0, vs0, fs0;

  assign active = (hcnt < H_ACT) && (vcnt < V_ACT);

  // Stage-0 control is gated by en so a disable aborts the frame on the same clock.
  always_comb begin
    act0 = en && active;
    hs0  = en && (hcnt >= HS_START) && (hcnt < HS_END);
    vs0  = en && (vcnt >= VS_START) && (vcnt < VS_END);
    fs0  = en && (hcnt == '0) && (vcnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0;
      vcnt <= '0;
      addr <= '0;
    end else if (!en) begin
      hcnt <= '0;
      vcnt <= '0;
      addr <= '0;
    end else begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
      if (active) addr <= (addr == A_LAST) ? '0 : addr + 1'b1;
    end
  end

  assign fb_raddr = addr;

  logic [RD_LAT-1:0] act_sr, hs_sr, vs_sr, fs_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_sr <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
      fs_sr  <= '0;
    end else begin
      act_sr[0] <= act0;
      hs_sr[0]  <= hs0;
      vs_sr[0]  <= vs0;
      fs_sr[0]  <= fs0;
      for (int i = 1; i < RD_LAT; i++) begin
        act_sr[i] <= act_sr[i-1];
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
        fs_sr[i]  <= fs_sr[i-1];
      end
    end
  end

  logic [23:0] pal [PAL_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= pal_default(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  logic        blank_q, hs_q, vs_q, fs_q;
  logic [23:0] rgb_q;

  // Final stage: lookup sees the palette before any write on this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      blank_q <= act_sr[RD_LAT-1];
      hs_q    <= hs_sr[RD_LAT-1];
      vs_q    <= vs_sr[RD_LAT-1];
      fs_q    <= fs_sr[RD_LAT-1];
      rgb_q   <= act_sr[RD_LAT-1] ? pal[fb_rdata] : 24'h0;
    end
  end

  assign blank       = blank_q;
  assign frame_start = fs_q;
  assign hsync       = hs_q ? HS_POL : ~HS_POL;
  assign vsync       = vs_q ? VS_POL : ~VS_POL;
  assign comp_sync   = BOTH_LOW ? (hsync ~^ vsync) : (hsync ^ vsync);
  assign pixel_r     = rgb_q[23:16];
  assign pixel_g     = rgb_q[15:8];
  assign pixel_b     = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard bench for vga_scanout across read latencies 1..4
module tb_vga_scanout;

  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int NPIX = HA * VA;

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [2:0] idx;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, en, pal_we;
  logic [2:0]  pal_addr;
  logic [23:0] pal_data;

  logic [3:0]  raddr_w [4];
  logic [2:0]  rdata_w [4];
  logic        blank_w [4], hs_w [4], vs_w [4], cs_w [4], fs_w [4];
  logic [7:0]  r_w [4], g_w [4], b_w [4];

  int total = 0;
  int bad = 0;
  int pos;

  ent_t        q [4][$];
  logic [23:0] pal_def [8] = '{24'h000000, 24'h00FF00, 24'h0000FF, 24'hFF0000,
                               24'h66FFFF, 24'hD3D3D3, 24'hFFFFFF, 24'hCCFF99};
  logic [23:0] pal_m [8];
  logic        pend_we;
  logic [2:0]  pend_a;
  logic [23:0] pend_d;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_lat
    logic [3:0] dly [4];

    always @(posedge clk) begin
      dly[0] <= raddr_w[g];
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
    end

    assign rdata_w[g] = dly[g][2:0];

    vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .IDX_W(3), .RD_LAT(g + 1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
      .fb_raddr(raddr_w[g]), .fb_rdata(rdata_w[g]),
      .blank(blank_w[g]), .hsync(hs_w[g]), .vsync(vs_w[g]), .comp_sync(cs_w[g]),
      .pixel_r(r_w[g]), .pixel_g(g_w[g]), .pixel_b(b_w[g]),
      .frame_start(fs_w[g])
    );
  end

  // Linear frame position; the reference derives everything from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pos <= 0;
    else if (!en) pos <= 0;
    else          pos <= (pos + 1) % FT;
  end

  always @(negedge clk) begin
    int h, v, ea;
    ent_t e0, e;
    logic eh, ev;
    logic [23:0] erg;
    h = pos % HT;
    v = pos / HT;
    ea = (v < VA) ? ((h < HA) ? v * HA + h : ((v + 1) * HA) % NPIX) : 0;
    e0.act = en && (h < HA) && (v < VA);
    e0.hs  = en && (h >= HA + HF) && (h < HA + HF + HSW);
    e0.vs  = en && (v >= VA + VF) && (v < VA + VF + VSW);
    e0.fs  = en && (pos == 0);
    e0.idx = 3'(ea);
    for (int l = 0; l < 4; l++) begin
      if (!rst_n) begin
        check($sformatf("reset_ctrl L%0d", l + 1),
              32'({blank_w[l], hs_w[l], vs_w[l], cs_w[l], fs_w[l]}), 32'b01110);
        check($sformatf("reset_rgb L%0d", l + 1), 32'({r_w[l], g_w[l], b_w[l]}), 32'h0);
        check($sformatf("reset_addr L%0d", l + 1), 32'(raddr_w[l]), 32'h0);
        q[l].delete();
        for (int i = 0; i <= l + 1; i++) q[l].push_back('0);
      end else begin
        check($sformatf("fb_raddr L%0d", l + 1), 32'(raddr_w[l]), 32'(ea));
        e = q[l].pop_front();
        eh = ~e.hs;
        ev = ~e.vs;
        erg = e.act ? pal_m[e.idx] : 24'h0;
        check($sformatf("ctrl L%0d", l + 1),
              32'({blank_w[l], hs_w[l], vs_w[l], cs_w[l], fs_w[l]}),
              32'({e.act, eh, ev, eh ~^ ev, e.fs}));
        check($sformatf("rgb L%0d", l + 1), 32'({r_w[l], g_w[l], b_w[l]}), 32'(erg));
        q[l].push_back(e0);
      end
    end
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) pal_m[i] = pal_def[i];
      pend_we = 1'b0;
    end else begin
      if (pend_we) pal_m[pend_a] = pend_d;
      pend_we = pal_we;
      pend_a  = pal_addr;
      pend_d  = pal_data;
    end
  end

  task automatic wait_pos(input int p);
    int guard = 0;
    while (pos != p && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("wait_pos", 32'(pos), 32'(p));
  endtask

  task automatic pal_write(input logic [2:0] a, input logic [23:0] d);
    pal_we = 1'b1;
    pal_addr = a;
    pal_data = d;
    @(posedge clk);
    #1;
    pal_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    pal_we = 1'b0;
    pal_addr = '0;
    pal_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 en = 1'b1;
    repeat (2 * FT + 5) @(posedge clk);
    #1;
    // Write lands on the same edge that the RD_LAT=2 instance looks up index 3.
    wait_pos(5);
    pal_write(3'd3, 24'h123456);
    repeat (FT) @(posedge clk);
    #1;
    wait_pos(14);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pal_write(3'd1, 24'h0A0B0C);
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    repeat (FT + 12) @(posedge clk);
    #1;
    pal_write(3'd6, 24'hABCDEF);
    wait_pos(20);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (FT + 12) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
